ysyx_23060208_sram_slave: RTL

AXI4-Lite single-port memory slave sitting directly downstream of the bus arbiter. It accepts one read or one write transaction at a time, inserts a pseudo-random response delay, and returns a response. The delay comes from an internal LFSR and exists to stress the IFU/EXU handshakes. Storage is an internal word array mapped at a fixed base address.

---
 rtl/ysyx_23060208_sram_slave.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060208_sram_slave.sv
// AXI4-Lite single-port memory slave with an LFSR-driven response delay.
// It handles one read or one write at a time and stores data as four byte-lane arrays.
module ysyx_23060208_sram_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    DELAY_BITS = 2,
    parameter logic [7:0]            LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [2:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = (DELAY_BITS > 0) ? DELAY_BITS : 1;
    localparam logic [ADDR_WIDTH-3:0] DEPTH_LIMIT = (ADDR_WIDTH-2)'(MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, R_WAIT, R_RESP, W_WAIT, W_RESP} state_t;

    state_t                state_reg, state_next;
    logic [7:0]            lfsr_reg;
    logic [CNT_W-1:0]      cnt_reg, cnt_next, delay_seed;
    logic [ADDR_WIDTH-1:0] addr_reg, off;
    logic [DATA_WIDTH-1:0] wdata_reg, rdata_reg, mem_word;
    logic [1:0]            size_reg, rresp_reg, bresp_reg;
    logic [ADDR_WIDTH-3:0] index;
    logic [IDX_W-1:0]      mem_idx;
    logic [3:0]            be;
    logic                  in_range, misaligned;
    logic                  rd_accept, wr_accept, rd_done, wr_done, wr_commit;
    logic                  unused_bits;

    assign rd_accept = (state_reg == IDLE) & arvalid;
    assign wr_accept = (state_reg == IDLE) & awvalid & wvalid & ~arvalid;
    assign rd_done   = (state_reg == R_WAIT) & (cnt_reg == '0);
    assign wr_done   = (state_reg == W_WAIT) & (cnt_reg == '0);

    // Decode always works from the latched address so it is stable through the wait.
    assign off        = addr_reg - BASE_ADDR;
    assign index      = off[ADDR_WIDTH-1:2];
    assign mem_idx    = index[IDX_W-1:0];
    assign in_range   = (addr_reg >= BASE_ADDR) && (index < DEPTH_LIMIT);
    assign misaligned = ((size_reg == 2'b01) && addr_reg[0]) ||
                        (size_reg[1] && (addr_reg[1:0] != 2'b00));
    assign wr_commit  = wr_done & in_range & ~misaligned;
    assign unused_bits = ^{wstrb[2], off[1:0]};

    always_comb begin
        be = 4'b1111;
        case (size_reg)
            2'b00:   be = 4'b0001 << addr_reg[1:0];
            2'b01:   be = addr_reg[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    generate
        if (DELAY_BITS == 0) begin : g_fixed_delay
            assign delay_seed = '0;
        end else begin : g_lfsr_delay
            assign delay_seed = lfsr_reg[CNT_W-1:0];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [MEM_DEPTH];
            always_ff @(posedge clk) begin
                if (wr_commit && be[gi]) begin
                    lane_mem[mem_idx] <= wdata_reg[8*gi +: 8];
                end
            end
            assign mem_word[8*gi +: 8] = lane_mem[mem_idx];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            lfsr_reg  <= LFSR_SEED;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            lfsr_reg  <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            size_reg  <= 2'b00;
            rdata_reg <= '0;
            rresp_reg <= 2'b00;
            bresp_reg <= 2'b00;
        end else begin
            if (rd_accept) begin
                addr_reg <= araddr;
            end else if (wr_accept) begin
                addr_reg  <= awaddr;
                wdata_reg <= wdata;
                size_reg  <= wstrb[1:0];
            end
            if (rd_done) begin
                rdata_reg <= in_range ? mem_word : '0;
                rresp_reg <= in_range ? 2'b00 : 2'b10;
            end
            if (wr_done) begin
                bresp_reg <= wr_commit ? 2'b00 : 2'b10;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        arready    = (state_reg == IDLE);
        awready    = wr_accept;
        wready     = wr_accept;
        case (state_reg)
            IDLE: begin
                if (rd_accept) begin
                    state_next = R_WAIT;
                    cnt_next   = delay_seed;
                end else if (wr_accept) begin
                    state_next = W_WAIT;
                    cnt_next   = delay_seed;
                end
            end
            R_WAIT: begin
                if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
                else               state_next = R_RESP;
            end
            R_RESP: if (rready) state_next = IDLE;
            W_WAIT: begin
                if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
                else               state_next = W_RESP;
            end
            W_RESP: if (bready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign rvalid = (state_reg == R_RESP);
    assign bvalid = (state_reg == W_RESP);
    assign rdata  = rdata_reg;
    assign rresp  = rresp_reg;
    assign bresp  = bresp_reg;

endmodule
